// File: rtl/isodata_pkg.sv
// Shared types and constants for the isodata engine scheduler.
package isodata_pkg;
  localparam int DEF_TIMEOUT  = 65536;
  localparam int DEF_MAX_ITER = 10;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_ABORT, S_RESP} sched_state_t;

  typedef struct packed {
    logic converged;
    logic timeout;
  } sched_status_t;

  // A budget of 0 or anything above the cap runs at the cap.
  function automatic logic [7:0] eff_iter(input logic [7:0] m, input logic [7:0] cap);
    return (m == 8'd0 || m > cap) ? cap : m;
  endfunction
endpackage

// File: rtl/isodata_engine_sched_if.sv
// Job-side and engine-side signals of the scheduler; master is the scheduler.
interface isodata_engine_sched_if #(
  parameter int R = 4
);
  localparam int IW = $clog2(R);

  logic [R-1:0]       req_valid;
  logic [R-1:0][7:0]  req_max_iter;
  logic [R-1:0]       req_ready;
  logic               eng_start;
  logic               eng_abort;
  logic [IW-1:0]      eng_sel;
  logic [7:0]         eng_max_iter;
  logic               eng_done;
  logic               eng_converged;
  logic [R-1:0]       rsp_valid;
  logic [R-1:0]       rsp_ready;
  logic               rsp_converged;
  logic               rsp_timeout;
  logic [15:0]        jobs_done;

  modport master (
    input  req_valid, req_max_iter, eng_done, eng_converged, rsp_ready,
    output req_ready, eng_start, eng_abort, eng_sel, eng_max_iter,
           rsp_valid, rsp_converged, rsp_timeout, jobs_done
  );

  modport slave (
    output req_valid, req_max_iter, eng_done, eng_converged, rsp_ready,
    input  req_ready, eng_start, eng_abort, eng_sel, eng_max_iter,
           rsp_valid, rsp_converged, rsp_timeout, jobs_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, with wrap.
module rr_arbiter #(
  parameter int R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] last_grant,
  output logic [R-1:0]         grant_onehot,
  output logic [$clog2(R)-1:0] grant_idx,
  output logic                 any
);
  localparam int IW = $clog2(R);

  always_comb begin
    int c;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    c            = 0;
    for (int i = 1; i <= R; i++) begin
      c = int'(last_grant) + i;
      if (c >= R) c = c - R;
      if (!any && req[c[IW-1:0]]) begin
        any                        = 1'b1;
        grant_idx                  = c[IW-1:0];
        grant_onehot[c[IW-1:0]]    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/isodata_engine_sched.sv
// Round-robin scheduler of R clustering jobs onto one isodata engine, with a
// watchdog that aborts runs that never report done.
module isodata_engine_sched
  import isodata_pkg::*;
#(
  parameter int R        = 4,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input logic                    clk,
  input logic                    rst_n,
  isodata_engine_sched_if.master bus
);
  localparam int              IW      = $clog2(R);
  localparam int              WW      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      CAP     = 8'(MAX_ITER);
  localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);

  sched_state_t  state_q, state_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    miter_q, miter_d;
  logic [WW-1:0] wd_q, wd_d;
  sched_status_t status_q, status_d;
  logic [15:0]   jobs_q, jobs_d;
  logic          live_q;

  logic [R-1:0]  grant_oh;
  logic [IW-1:0] grant_idx;
  logic          grant_any;
  logic [R-1:0]  req_ready, rsp_valid;
  logic          eng_start, eng_abort;

  rr_arbiter #(.R(R)) u_arb (
    .req          (bus.req_valid),
    .last_grant   (last_q),
    .grant_onehot (grant_oh),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    miter_d   = miter_q;
    wd_d      = wd_q;
    status_d  = status_q;
    jobs_d    = jobs_q;
    req_ready = '0;
    rsp_valid = '0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        // live_q keeps req_ready low while reset is asserted
        if (grant_any && live_q) begin
          req_ready = grant_oh;
          sel_d     = grant_idx;
          miter_d   = eff_iter(bus.req_max_iter[grant_idx], CAP);
          wd_d      = '0;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        eng_start = 1'b1;
        wd_d      = wd_q + WW'(1);
        state_d   = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + WW'(1);
        // done on the expiry cycle still counts as a normal finish
        if (bus.eng_done) begin
          status_d = '{converged: bus.eng_converged, timeout: 1'b0};
          state_d  = S_RESP;
        end else if (wd_q == WD_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        eng_abort = 1'b1;
        status_d  = '{converged: 1'b0, timeout: 1'b1};
        state_d   = S_RESP;
      end
      S_RESP: begin
        rsp_valid[sel_q] = 1'b1;
        if (bus.rsp_ready[sel_q]) begin
          last_d  = sel_q;
          jobs_d  = (jobs_q == 16'hFFFF) ? jobs_q : jobs_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      last_q   <= IW'(R - 1);
      miter_q  <= '0;
      wd_q     <= '0;
      status_q <= '0;
      jobs_q   <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      miter_q  <= miter_d;
      wd_q     <= wd_d;
      status_q <= status_d;
      jobs_q   <= jobs_d;
      live_q   <= 1'b1;
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.eng_start     = eng_start;
  assign bus.eng_abort     = eng_abort;
  assign bus.eng_sel       = sel_q;
  assign bus.eng_max_iter  = miter_q;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_converged = status_q.converged;
  assign bus.rsp_timeout   = status_q.timeout;
  assign bus.jobs_done     = jobs_q;
endmodule
